pio_read_arbiter: RTL and testbench
===================================

PIO_READ_ARBITER -- requirements
Module: pio_read_arbiter

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-high.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 req0_valid  input  1  requester 0 read request; held high with req0_address stable until req0_ready.
REQ-005 req0_address  input  2  requester 0 PIO register address.
REQ-006 req0_ready  output  1  one-cycle grant/accept pulse to requester 0.
REQ-007 rsp0_valid  output  1  one-cycle read-response strobe to requester 0.
REQ-008 rsp0_data  output  32  read data to requester 0, valid when rsp0_valid high.
REQ-009 req1_valid, req1_address, req1_ready, rsp1_valid, rsp1_data SHALL exist with the same directions, widths and meanings for requester 1.
REQ-010 pio_address  output  2  address to shared PIO slave.
REQ-011 pio_readdata  input  32  PIO slave read data, registered by the slave one clock after pio_address.

Function
REQ-012 FSM states SHALL be IDLE, ADDR, DATA, RESP; each non-IDLE state lasts exactly one cycle.
REQ-013 IDLE: if any reqN_valid, select a winner, latch its index and address, next state ADDR; else stay IDLE.
REQ-014 ADDR: pio_address SHALL equal latched address; winner's reqN_ready SHALL be 1; next DATA.
REQ-015 DATA: pio_address SHALL still equal latched address; pio_readdata SHALL be captured into winner's rspN_data at end of cycle; next RESP.
REQ-016 RESP: winner's rspN_valid SHALL be 1 for exactly this cycle; next IDLE.
REQ-017 Request-to-response latency SHALL be 3 cycles (request seen in IDLE at cycle T, ready at T+1, rsp_valid at T+3); throughput is one read per 4 cycles.
REQ-018 pio_address SHALL be 0 in IDLE and RESP.
REQ-019 At most one of req0_ready/req1_ready and at most one of rsp0_valid/rsp1_valid SHALL be high in any cycle.
REQ-020 Single requester SHALL always win regardless of priority state.
REQ-021 Both requesting in IDLE: grant per REQ-028/029; last_grant register updated on every selection.
REQ-022 reqN_valid deasserted after selection SHALL NOT abort the transaction; response still issued.
REQ-023 rspN_data SHALL hold its value until the next response to that requester.
REQ-024 Requests arriving in ADDR/DATA/RESP SHALL wait; evaluated only in IDLE.

Reset
REQ-025 On reset assertion (any state, asynchronously): state IDLE, all ready/valid 0, rsp0_data = rsp1_data = 0, pio_address = 0, last_grant = 1.
REQ-026 An in-flight transaction interrupted by reset SHALL produce no response after reset release.
REQ-027 First arbitration after reset with both requesting SHALL grant requester 0.

Configuration
REQ-028 Macro PIO_ARB_FIXED_PRI_EN defined: requester 0 SHALL win every tie; last_grant unused for decisions.
REQ-029 PIO_ARB_FIXED_PRI_EN undefined (default): round-robin; on tie grant the requester not equal to last_grant.

Verification
REQ-030 Single read: req0_valid=1, addr=0, pio_readdata=32'h1 -> req0_ready at T+1, pio_address=0 at T+1..T+2, rsp0_valid at T+3 with rsp0_data=32'h1.
REQ-031 Tie, round-robin: both valid continuously, addresses 0 and 1 -> grants 0,1,0,1 every 4 cycles; never two ready same cycle.
REQ-032 Tie, PIO_ARB_FIXED_PRI_EN defined: both valid continuously -> requester 0 granted every time, requester 1 never.
REQ-033 Withdrawal: req1_valid high in IDLE, low in ADDR -> rsp1_valid still at T+3 with captured pio_readdata (e.g. 32'h0).
REQ-034 Reset in DATA state: assert reset 1 cycle -> all outputs 0 immediately, no rsp_valid afterwards; next tie grants requester 0.
REQ-035 Late request: req1_valid rises in ADDR of req0 transaction -> req1_ready exactly 4 cycles after req0_ready.

Source files
------------

// File: rtl/pio_read_arbiter.sv
// Two requesters share one PIO read port: ready at T+1, response at T+3, one read per 4 cycles.
// Losers wait with valid held; ties alternate round-robin unless PIO_ARB_FIXED_PRI_EN fixes priority on requester 0.
module pio_read_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [1:0]  req0_address,
  output logic        req0_ready,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_data,
  input  logic        req1_valid,
  input  logic [1:0]  req1_address,
  output logic        req1_ready,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_data,
  output logic [1:0]  pio_address,
  input  logic [31:0] pio_readdata
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t      state_q, state_d;
  logic        win_q, win_d;
  logic [1:0]  addr_q, addr_d;
  logic [31:0] rsp0_data_q, rsp0_data_d;
  logic [31:0] rsp1_data_q, rsp1_data_d;
  logic        tie_pick;
  logic        select;

  assign select = (state_q == IDLE) && (req0_valid || req1_valid);

`ifdef PIO_ARB_FIXED_PRI_EN
  assign tie_pick = 1'b0;
`else
  logic last_grant_q, last_grant_d;

  // Reset value 1 makes the first tie go to requester 0.
  assign tie_pick     = ~last_grant_q;
  assign last_grant_d = select ? win_d : last_grant_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    addr_d      = addr_q;
    rsp0_data_d = rsp0_data_q;
    rsp1_data_d = rsp1_data_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    rsp0_valid  = 1'b0;
    rsp1_valid  = 1'b0;
    pio_address = 2'd0;
    case (state_q)
      IDLE: begin
        if (select) begin
          win_d   = (req0_valid && req1_valid) ? tie_pick : req1_valid;
          addr_d  = win_d ? req1_address : req0_address;
          state_d = ADDR;
        end
      end
      ADDR: begin
        pio_address = addr_q;
        req0_ready  = ~win_q;
        req1_ready  = win_q;
        state_d     = DATA;
      end
      DATA: begin
        // Slave registers read data, so it arrives the cycle after the address.
        pio_address = addr_q;
        if (win_q) begin
          rsp1_data_d = pio_readdata;
        end else begin
          rsp0_data_d = pio_readdata;
        end
        state_d = RESP;
      end
      RESP: begin
        rsp0_valid = ~win_q;
        rsp1_valid = win_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      win_q       <= 1'b0;
      addr_q      <= 2'd0;
      rsp0_data_q <= 32'd0;
      rsp1_data_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      addr_q      <= addr_d;
      rsp0_data_q <= rsp0_data_d;
      rsp1_data_q <= rsp1_data_d;
    end
  end

  assign rsp0_data = rsp0_data_q;
  assign rsp1_data = rsp1_data_q;

endmodule

// File: tb/tb_pio_read_arbiter.sv
// Bench for pio_read_arbiter: transaction-level model checked every cycle, plus directed literal cases.
module tb_pio_read_arbiter;

`ifdef PIO_ARB_FIXED_PRI_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0;
  logic [1:0]  req0_address = 2'd0;
  logic        req1_valid = 1'b0;
  logic [1:0]  req1_address = 2'd0;
  logic [31:0] pio_readdata = 32'd0;
  logic        req0_ready, rsp0_valid, req1_ready, rsp1_valid;
  logic [31:0] rsp0_data, rsp1_data;
  logic [1:0]  pio_address;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  pio_read_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .req0_valid   (req0_valid),
    .req0_address (req0_address),
    .req0_ready   (req0_ready),
    .rsp0_valid   (rsp0_valid),
    .rsp0_data    (rsp0_data),
    .req1_valid   (req1_valid),
    .req1_address (req1_address),
    .req1_ready   (req1_ready),
    .rsp1_valid   (rsp1_valid),
    .rsp1_data    (rsp1_data),
    .pio_address  (pio_address),
    .pio_readdata (pio_readdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: one transaction record (start cycle, winner, address); every
  // output follows from cycle offsets relative to the start of the selection.
  int          m_start = -100;
  bit          m_win = 1'b0;
  bit          m_last = 1'b1;
  logic [1:0]  m_addr = 2'd0;
  logic [31:0] m_cap = 32'd0;
  logic [31:0] m_data [2] = '{32'd0, 32'd0};

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
      chk("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
      chk("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
      chk("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
      chk("rst_pio_address", {30'd0, pio_address}, 32'd0);
      chk("rst_rsp0_data", rsp0_data, 32'd0);
      chk("rst_rsp1_data", rsp1_data, 32'd0);
      m_start = -100;
      m_last  = 1'b1;
      m_data[0] = 32'd0;
      m_data[1] = 32'd0;
    end else begin
      bit e_r0, e_r1, e_v0, e_v1;
      logic [1:0] e_pio;
      if (cyc == m_start + 2) m_cap = pio_readdata;
      if (cyc == m_start + 3) m_data[m_win] = m_cap;
      e_r0  = (cyc == m_start + 1) && !m_win;
      e_r1  = (cyc == m_start + 1) && m_win;
      e_v0  = (cyc == m_start + 3) && !m_win;
      e_v1  = (cyc == m_start + 3) && m_win;
      e_pio = (cyc == m_start + 1 || cyc == m_start + 2) ? m_addr : 2'd0;
      chk("m_req0_ready", {31'd0, req0_ready}, {31'd0, e_r0});
      chk("m_req1_ready", {31'd0, req1_ready}, {31'd0, e_r1});
      chk("m_rsp0_valid", {31'd0, rsp0_valid}, {31'd0, e_v0});
      chk("m_rsp1_valid", {31'd0, rsp1_valid}, {31'd0, e_v1});
      chk("m_pio_address", {30'd0, pio_address}, {30'd0, e_pio});
      chk("m_rsp0_data", rsp0_data, m_data[0]);
      chk("m_rsp1_data", rsp1_data, m_data[1]);
      if (cyc >= m_start + 4 && (req0_valid || req1_valid)) begin
        if (req0_valid && req1_valid) m_win = FIXED ? 1'b0 : !m_last;
        else m_win = req1_valid;
        m_addr  = m_win ? req1_address : req0_address;
        m_last  = m_win;
        m_start = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    logic [1:0]  s_addr [2];
    logic [31:0] s_data [2];
    int          grants [$];
    int          t_r0, gap;
    bit          vld [2];
    bit          drop_next [2];
    logic [1:0]  adr [2];

    repeat (3) tick();
    reset = 1'b0;
    idle_cycles(2);

    // Single reads from requester 0.
    s_addr[0] = 2'd0; s_data[0] = 32'h1;
    s_addr[1] = 2'd3; s_data[1] = 32'hA5A5_0003;
    for (int i = 0; i < 2; i++) begin
      req0_valid = 1'b1; req0_address = s_addr[i]; pio_readdata = s_data[i];
      tick();
      chk("single_ready_t1", {31'd0, req0_ready}, 32'd1);
      chk("single_pio_t1", {30'd0, pio_address}, {30'd0, s_addr[i]});
      req0_valid = 1'b0;
      tick();
      chk("single_pio_t2", {30'd0, pio_address}, {30'd0, s_addr[i]});
      tick();
      chk("single_rsp_valid_t3", {31'd0, rsp0_valid}, 32'd1);
      chk("single_rsp_data_t3", rsp0_data, s_data[i]);
      chk("single_pio_t3", {30'd0, pio_address}, 32'd0);
      idle_cycles(2);
    end

    // Requester 1 withdraws valid during ADDR; response must still arrive.
    req1_valid = 1'b1; req1_address = 2'd2; pio_readdata = 32'hDEAD_0001;
    tick();
    chk("wd_ready1", {31'd0, req1_ready}, 32'd1);
    chk("wd_ready0", {31'd0, req0_ready}, 32'd0);
    req1_valid = 1'b0;
    tick();
    tick();
    chk("wd_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
    chk("wd_rsp1_data", rsp1_data, 32'hDEAD_0001);
    chk("wd_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    idle_cycles(2);

    // Request arriving during ADDR of another transaction waits for the next IDLE.
    req0_valid = 1'b1; req0_address = 2'd1;
    tick();
    chk("late_ready0", {31'd0, req0_ready}, 32'd1);
    t_r0 = cyc;
    req0_valid = 1'b0; req1_valid = 1'b1; req1_address = 2'd3;
    gap = -1;
    for (int i = 0; i < 8 && gap < 0; i++) begin
      tick();
      if (req1_ready) begin
        gap = cyc - t_r0;
        req1_valid = 1'b0;
      end
    end
    chk("late_gap", gap, 32'd4);
    idle_cycles(3);

    // Reset during DATA: outputs clear immediately, no stale response afterwards.
    req1_valid = 1'b1; req1_address = 2'd2; pio_readdata = 32'h1234_5678;
    tick();
    req1_valid = 1'b0;
    tick();
    #2 reset = 1'b1;
    #1;
    chk("arst_req0_ready", {31'd0, req0_ready}, 32'd0);
    chk("arst_req1_ready", {31'd0, req1_ready}, 32'd0);
    chk("arst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    chk("arst_pio_address", {30'd0, pio_address}, 32'd0);
    chk("arst_rsp0_data", rsp0_data, 32'd0);
    chk("arst_rsp1_data", rsp1_data, 32'd0);
    req0_valid = 1'b1; req0_address = 2'd0;
    req1_valid = 1'b1; req1_address = 2'd1;
    tick();
    reset = 1'b0;

    // Continuous tie straight out of reset.
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("tie_one_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
    end
    chk("tie_grant_count", grants.size(), 32'd4);
    for (int j = 0; j < grants.size() && j < 4; j++)
      chk("tie_grant_order", grants[j], FIXED ? 32'd0 : (j % 2));
    idle_cycles(4);

    // Randomised traffic; requesters hold valid/address until granted, sometimes withdraw in ADDR.
    vld = '{1'b0, 1'b0};
    drop_next = '{1'b0, 1'b0};
    adr = '{2'd0, 2'd0};
    for (int c = 0; c < 3000; c++) begin
      for (int r = 0; r < 2; r++) begin
        bit rdy;
        rdy = (r == 0) ? req0_ready : req1_ready;
        if (vld[r] && rdy) begin
          if ($urandom_range(1, 0) == 0) vld[r] = 1'b0;
          else drop_next[r] = 1'b1;
        end else if (drop_next[r]) begin
          vld[r] = 1'b0;
          drop_next[r] = 1'b0;
        end else if (!vld[r] && $urandom_range(2, 0) == 0) begin
          vld[r] = 1'b1;
          adr[r] = 2'($urandom_range(3, 0));
        end
      end
      req0_valid = vld[0]; req0_address = adr[0];
      req1_valid = vld[1]; req1_address = adr[1];
      pio_readdata = $urandom;
      tick();
    end
    idle_cycles(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
